// File: rtl/datapath_sequencer.sv
// Micro-sequencer that drives a Datapath register file/ALU from a small writable
// program memory: ALU write-back micro-ops plus HALT / BZ / BNZ / JMP control ops.

module datapath_sequencer_checker (
   input logic clk,
   input logic rst,
   input logic wr,
   input logic busy,
   input logic done,
   input logic err
);

   a_wr_single : assert property (@(posedge clk) disable iff (!rst) wr |=> !wr);
   a_wr_busy   : assert property (@(posedge clk) disable iff (!rst) wr |-> busy);
   a_status    : assert property (@(posedge clk) disable iff (!rst)
                                  !(busy && (done || err)) && !(done && err));
   a_done_once : assert property (@(posedge clk) disable iff (!rst) done |=> !done);
   a_err_once  : assert property (@(posedge clk) disable iff (!rst) err |=> !err);

endmodule

module datapath_sequencer #(
   parameter int  PROG_DEPTH = 16,
   parameter int  MAX_STEPS  = 255,
   localparam int PC_W       = $clog2(PROG_DEPTH),
   localparam int STEP_W     = $clog2(MAX_STEPS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            prog_we,
   input  logic [PC_W-1:0] prog_addr,
   input  logic [11:0]     prog_data,
   input  logic            start,
   input  logic            Zero,
   output logic [1:0]      addr1,
   output logic [1:0]      addr2,
   output logic [1:0]      addr3,
   output logic [2:0]      ALUControl,
   output logic            wr,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ABORT = 3'd4
   } state_t;

   localparam logic [1:0]        OP_HALT    = 2'b00;
   localparam logic [1:0]        OP_BZ      = 2'b01;
   localparam logic [1:0]        OP_BNZ     = 2'b10;
   localparam logic [1:0]        OP_JMP     = 2'b11;
   localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

   logic [11:0]       mem_r [PROG_DEPTH];
   state_t            state_r;
   state_t            state_nxt_s;
   logic [PC_W-1:0]   pc_r;
   logic [PC_W-1:0]   pc_nxt_s;
   logic [PC_W-1:0]   pc_inc_s;
   logic [STEP_W-1:0] steps_r;
   logic [11:0]       fetch_word_s;
   logic              ctl_r;
   logic [1:0]        op_r;
   logic [PC_W-1:0]   tgt_r;
   logic              zflag_r;
   logic [1:0]        addr1_r;
   logic [1:0]        addr2_r;
   logic [1:0]        addr3_r;
   logic [2:0]        alu_ctl_r;
   logic              wr_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic              start_ok_s;
   logic              fetch_ok_s;
   logic              abort_s;
   logic              halt_s;
   logic              load_alu_s;

   // Next state, next pc and the one-cycle transition strobes.
   always_comb begin
      state_nxt_s  = state_r;
      pc_nxt_s     = pc_r;
      fetch_word_s = mem_r[pc_r];
      pc_inc_s     = pc_r + PC_W'(1);
      start_ok_s   = 1'b0;
      fetch_ok_s   = 1'b0;
      abort_s      = 1'b0;
      halt_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               start_ok_s  = 1'b1;
               pc_nxt_s    = {PC_W{1'b0}};
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // The budget is checked before counting, so MAX_STEPS instructions do run.
            if (steps_r == STEP_LIMIT) begin
               abort_s     = 1'b1;
               state_nxt_s = ST_ABORT;
            end else begin
               fetch_ok_s  = 1'b1;
               state_nxt_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt_s = ST_FETCH;
            if (!ctl_r) begin
               pc_nxt_s = pc_inc_s;
            end else begin
               case (op_r)
                  OP_HALT: begin
                     halt_s      = 1'b1;
                     state_nxt_s = ST_DONE;
                  end
                  OP_BZ:   pc_nxt_s = zflag_r ? tgt_r : pc_inc_s;
                  OP_BNZ:  pc_nxt_s = zflag_r ? pc_inc_s : tgt_r;
                  OP_JMP:  pc_nxt_s = tgt_r;
                  default: pc_nxt_s = pc_inc_s;
               endcase
            end
         end
         ST_DONE:  state_nxt_s = ST_IDLE;
         ST_ABORT: state_nxt_s = ST_IDLE;
         default:  state_nxt_s = ST_IDLE;
      endcase
   end

   assign load_alu_s = fetch_ok_s & ~fetch_word_s[11];

   // Sequencer state plus the registered Datapath-facing controls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         pc_r      <= {PC_W{1'b0}};
         steps_r   <= {STEP_W{1'b0}};
         ctl_r     <= 1'b0;
         op_r      <= 2'b00;
         tgt_r     <= {PC_W{1'b0}};
         zflag_r   <= 1'b0;
         addr1_r   <= 2'b00;
         addr2_r   <= 2'b00;
         addr3_r   <= 2'b00;
         alu_ctl_r <= 3'b000;
         wr_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         pc_r    <= pc_nxt_s;
         wr_r    <= load_alu_s;
         busy_r  <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_EXEC);
         done_r  <= halt_s;
         err_r   <= abort_s;
         if (start_ok_s) begin
            steps_r <= {STEP_W{1'b0}};
            zflag_r <= 1'b0;
         end else if (fetch_ok_s) begin
            steps_r <= steps_r + STEP_W'(1);
         end else if ((state_r == ST_EXEC) && !ctl_r) begin
            zflag_r <= Zero;
         end
         if (fetch_ok_s) begin
            ctl_r <= fetch_word_s[11];
            op_r  <= fetch_word_s[10:9];
            tgt_r <= fetch_word_s[PC_W-1:0];
         end
         // Control ops leave the Datapath operand lines where the last ALU op put them.
         if (load_alu_s) begin
            alu_ctl_r <= fetch_word_s[10:8];
            addr1_r   <= fetch_word_s[7:6];
            addr2_r   <= fetch_word_s[5:4];
            addr3_r   <= fetch_word_s[3:2];
         end
      end
   end

   // Program store: loadable only while idle and intentionally kept across resets.
   always_ff @(posedge clk) begin
      if (prog_we && (state_r == ST_IDLE)) begin
         mem_r[prog_addr] <= prog_data;
      end
   end

   assign addr1      = addr1_r;
   assign addr2      = addr2_r;
   assign addr3      = addr3_r;
   assign ALUControl = alu_ctl_r;
   assign wr         = wr_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;
   assign pc         = pc_r;

   datapath_sequencer_checker u_checker (
      .clk  (clk),
      .rst  (rst),
      .wr   (wr_r),
      .busy (busy_r),
      .done (done_r),
      .err  (err_r)
   );

endmodule

// File: tb/tb_datapath_sequencer.sv
// Table-driven bench for datapath_sequencer with a small Datapath register-file/ALU model.
`timescale 1ns/1ps
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = 4'd0;
   logic [11:0] prog_data = 12'd0;
   logic        start = 1'b0;
   logic        zero_s;
   logic [1:0]  addr1, addr2, addr3;
   logic [2:0]  alu_ctl;
   logic        wr, busy, done, err;
   logic [3:0]  pc;

   always #5 clk = ~clk;

   datapath_sequencer dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .Zero(zero_s),
      .addr1(addr1), .addr2(addr2), .addr3(addr3), .ALUControl(alu_ctl),
      .wr(wr), .busy(busy), .done(done), .err(err), .pc(pc)
   );

   logic [15:0] rf [4];
   logic [15:0] rf_init [4];
   logic        rf_load = 1'b0;
   logic [15:0] alu_res;

   always_comb begin
      case (alu_ctl)
         3'b000:  alu_res = rf[addr1] + rf[addr2];
         3'b001:  alu_res = rf[addr1] - rf[addr2];
         3'b010:  alu_res = rf[addr1] & rf[addr2];
         3'b011:  alu_res = rf[addr1] | rf[addr2];
         default: alu_res = rf[addr1];
      endcase
   end
   assign zero_s = (alu_res == 16'h0000);

   always @(posedge clk) begin
      if (rf_load) begin
         for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
      end else if (wr) begin
         rf[addr3] <= alu_res;
      end
   end

   typedef struct packed {
      logic [63:0] rf0;      // {R3,R2,R1,R0}
      logic [63:0] rf_exp;
      logic [31:0] cycles;   // negedges after start accepted until done/err seen
      logic        ex_done;
      logic        ex_err;
      logic [7:0]  wrs;
      logic [3:0]  pc_end;
      logic [31:0] trace;    // distinct pc values while busy, 4 bits each
      logic [7:0]  tlen;
      logic [8:0]  tag;      // {ALUControl,addr1,addr2,addr3} at first wr
   } vec_t;

   vec_t        vecs [5];
   logic [11:0] progs [5][16];

   int          n_chk = 0;
   int          n_fail = 0;

   int          r_cycles, r_wrs, r_dbl, r_bbad, r_tlen;
   logic        r_done, r_err, r_post;
   logic [31:0] r_trace;
   logic [3:0]  r_pc;
   logic [8:0]  r_tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load_rf(input logic [63:0] v);
      for (int i = 0; i < 4; i++) rf_init[i] = v[16*i +: 16];
      @(negedge clk);
      rf_load = 1'b1;
      @(negedge clk);
      rf_load = 1'b0;
   endtask

   task automatic load_prog(input int k);
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         prog_we   = 1'b1;
         prog_addr = 4'(a);
         prog_data = progs[k][a];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic run_prog(input int limit, input logic st_we, input logic mid_we);
      logic       wp;
      logic [3:0] lastpc;
      r_cycles = 0; r_wrs = 0; r_dbl = 0; r_bbad = 0; r_tlen = 0;
      r_done = 1'b0; r_err = 1'b0; r_trace = 32'd0; r_pc = 4'd0; r_tag = 9'd0;
      wp = 1'b0; lastpc = 4'd0;
      @(negedge clk);
      start = 1'b1;
      if (st_we) begin
         prog_we = 1'b1; prog_addr = 4'd0; prog_data = 12'h800;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      prog_we = 1'b0;
      while (r_cycles < limit && !r_done && !r_err) begin
         @(negedge clk);
         r_cycles++;
         if (mid_we && r_cycles == 1) begin
            prog_we = 1'b1; prog_addr = 4'd1; prog_data = 12'h090;
         end else begin
            prog_we = 1'b0;
         end
         if (wr) begin
            if (r_wrs == 0) r_tag = {alu_ctl, addr1, addr2, addr3};
            r_wrs++;
            if (wp) r_dbl++;
         end
         wp = wr;
         if (busy && (r_tlen == 0 || pc != lastpc)) begin
            r_trace = {r_trace[27:0], pc};
            r_tlen++;
            lastpc = pc;
         end
         if (busy == (done | err)) r_bbad++;
         r_pc = pc; r_done = done; r_err = err;
      end
      prog_we = 1'b0;
      @(negedge clk);
      r_post = done | err | busy;
   endtask

   initial begin
      for (int k = 0; k < 5; k++)
         for (int a = 0; a < 16; a++) progs[k][a] = 12'h800;
      progs[0][0] = 12'h154;
      progs[1][0] = 12'h154; progs[1][1] = 12'h090; progs[1][2] = 12'h178; progs[1][3] = 12'h03C;
      progs[2][0] = 12'h154; progs[2][1] = 12'hA05; progs[2][2] = 12'h0B0;
      progs[3][0] = 12'h154; progs[3][1] = 12'hC05; progs[3][2] = 12'h0B0;
      progs[4][0] = 12'hE00;
      vecs[0] = '{rf0: 64'h0000_0000_0005_0000, rf_exp: 64'h0000_0000_0000_0000, cycles: 32'd5,
                  ex_done: 1'b1, ex_err: 1'b0, wrs: 8'd1, pc_end: 4'd1, trace: 32'h01, tlen: 8'd2, tag: 9'h055};
      vecs[1] = '{rf0: 64'h0001_FFFF_5555_1234, rf_exp: 64'h0000_FFFF_0000_FFFF, cycles: 32'd11,
                  ex_done: 1'b1, ex_err: 1'b0, wrs: 8'd4, pc_end: 4'd4, trace: 32'h01234, tlen: 8'd5, tag: 9'h055};
      vecs[2] = '{rf0: 64'h0004_0003_0007_AAAA, rf_exp: 64'h0004_0003_0000_AAAA, cycles: 32'd7,
                  ex_done: 1'b1, ex_err: 1'b0, wrs: 8'd1, pc_end: 4'd5, trace: 32'h015, tlen: 8'd3, tag: 9'h055};
      vecs[3] = '{rf0: 64'h0004_0003_0007_AAAA, rf_exp: 64'h0004_0003_0000_0007, cycles: 32'd9,
                  ex_done: 1'b1, ex_err: 1'b0, wrs: 8'd2, pc_end: 4'd3, trace: 32'h0123, tlen: 8'd4, tag: 9'h055};
      vecs[4] = '{rf0: 64'h4444_3333_2222_1111, rf_exp: 64'h4444_3333_2222_1111, cycles: 32'd512,
                  ex_done: 1'b0, ex_err: 1'b1, wrs: 8'd0, pc_end: 4'd0, trace: 32'h0, tlen: 8'd1, tag: 9'h000};

      #3 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ctl", {wr, busy, done, err}, 4'b0000);
      check("reset_pc", pc, 4'd0);
      check("reset_dp", {alu_ctl, addr1, addr2, addr3}, 9'd0);
      rst = 1'b1;

      for (int k = 0; k < 5; k++) begin
         load_rf(vecs[k].rf0);
         load_prog(k);
         run_prog(600, 1'b0, 1'b0);
         check($sformatf("v%0d_cycles", k), r_cycles, vecs[k].cycles);
         check($sformatf("v%0d_done", k), r_done, vecs[k].ex_done);
         check($sformatf("v%0d_err", k), r_err, vecs[k].ex_err);
         check($sformatf("v%0d_wr_count", k), r_wrs, vecs[k].wrs);
         check($sformatf("v%0d_wr_double", k), r_dbl, 0);
         check($sformatf("v%0d_pc_trace", k), r_trace, vecs[k].trace);
         check($sformatf("v%0d_pc_trace_len", k), r_tlen, vecs[k].tlen);
         check($sformatf("v%0d_pc_end", k), r_pc, vecs[k].pc_end);
         check($sformatf("v%0d_first_wr", k), r_tag, vecs[k].tag);
         check($sformatf("v%0d_busy", k), r_bbad, 0);
         check($sformatf("v%0d_post_idle", k), r_post, 1'b0);
         check($sformatf("v%0d_regs", k), {rf[3], rf[2], rf[1], rf[0]}, vecs[k].rf_exp);
      end

      // start together with a write of HALT to mem[0]
      load_rf(vecs[0].rf0);
      load_prog(0);
      run_prog(20, 1'b1, 1'b0);
      check("stwe_done", r_done, 1'b1);
      check("stwe_cycles", r_cycles, 3);
      check("stwe_wr_count", r_wrs, 0);

      // write attempted mid-run must not land
      load_prog(0);
      run_prog(20, 1'b0, 1'b1);
      check("midwe_run1_cycles", r_cycles, 5);
      check("midwe_run1_wr_count", r_wrs, 1);
      run_prog(20, 1'b0, 1'b0);
      check("midwe_run2_cycles", r_cycles, 5);
      check("midwe_run2_wr_count", r_wrs, 1);
      check("midwe_run2_trace", r_trace, 32'h01);

      // reset while the write strobe is high
      load_rf(vecs[0].rf0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      r_cycles = 0;
      while (!wr && r_cycles < 10) begin
         @(negedge clk);
         r_cycles++;
      end
      check("rst_wr_seen", wr, 1'b1);
      rst = 1'b0;
      #1;
      check("rst_async_ctl", {wr, busy, done, err}, 4'b0000);
      check("rst_async_pc", pc, 4'd0);
      repeat (3) @(negedge clk);
      check("rst_hold_status", {busy, done, err}, 3'b000);
      check("rst_write_dropped", rf[1], 16'h0005);
      rst = 1'b1;
      run_prog(20, 1'b0, 1'b0);
      check("rst_rerun_done", r_done, 1'b1);
      check("rst_rerun_cycles", r_cycles, 5);
      check("rst_rerun_r1", rf[1], 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Control-side counterpart to Datapath: the block that drives addr1/addr2/addr3, ALUControl and wr, and consumes Zero, instead of a bench hand-driving them. It holds a small program memory loaded over a write port and, on start, steps through micro-instructions. Each instruction is either an ALU write-back op or a control op (branch on Zero, jump, halt). It reports completion or a step-limit abort.

Parameters:
PROG_DEPTH, 16, program memory entries; PC width = log2(PROG_DEPTH) = 4.
MAX_STEPS, 255, maximum instructions executed per run before abort.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
prog_we  in  1  program memory write strobe, honoured only in IDLE
prog_addr  in  4  program memory write address
prog_data  in  12  instruction word
start  in  1  begin execution at pc=0, honoured only in IDLE
Zero  in  1  Datapath ALU zero flag, combinational from current addr1/addr2/ALUControl
addr1  out  2  Datapath source register A
addr2  out  2  Datapath source register B
addr3  out  2  Datapath destination register
ALUControl  out  3  Datapath ALU operation (000 ADD, 001 SUB, others passed through)
wr  out  1  Datapath register write enable
busy  out  1  high from the cycle after start is accepted until done/err
done  out  1  one-cycle pulse on HALT
err  out  1  one-cycle pulse on MAX_STEPS abort
pc  out  4  current program counter

Behaviour:
- Instruction format:
  - bit11=0, ALU op: [10:8] ALUControl, [7:6] addr1, [5:4] addr2, [3:2] addr3, [1:0] ignored.
  - bit11=1, control op: [10:9] 00 HALT, 01 BZ, 10 BNZ, 11 JMP; [3:0] target; other bits ignored.
- Reset (rst=0, async): state IDLE; pc=0; addr1/addr2/addr3/ALUControl=0; wr/busy/done/err=0; zflag=0; step count=0. Program memory is not reset; contents are retained.
- States: IDLE, FETCH, EXEC, DONE, ABORT.
  - IDLE: prog_we writes mem[prog_addr] at the clock edge. If start=1, pc<=0, steps<=0, go to FETCH. start and prog_we in the same cycle: both take effect, and the write is visible to the first FETCH.
  - FETCH: ir<=mem[pc]; steps<=steps+1. If steps==MAX_STEPS before the increment, go to ABORT; otherwise go to EXEC.
  - EXEC, ALU op: drive addr1/addr2/addr3/ALUControl from ir and wr=1 for exactly this cycle; zflag<=Zero at the end of the cycle; pc<=pc+1; go to FETCH.
  - EXEC, BZ: pc<=target if zflag=1, else pc+1.
  - EXEC, BNZ: pc<=target if zflag=0, else pc+1.
  - EXEC, JMP: pc<=target unconditionally.
  - EXEC, HALT: pc unchanged; go to DONE.
  - In EXEC for any control op: wr=0 and addr/ALUControl hold their previous values.
  - DONE: done=1 for one cycle, then IDLE. ABORT: err=1 for one cycle, then IDLE. busy is 0 in both.
- Timing: ALU op takes 2 cycles (FETCH+EXEC); control op takes 2 cycles; HALT adds the one DONE cycle.
- wr is registered; it is never high outside EXEC of an ALU op and never high for two consecutive cycles.
- zflag changes only on ALU ops; control ops do not modify it; it is cleared when start is accepted.
- pc+1 wraps 15->0 with no error.
- start while busy: ignored. prog_we while not in IDLE: ignored, memory unchanged.
- Reset asserted mid-run: immediate return to IDLE with every output at its reset value; no done/err pulse; the Datapath write in flight is dropped because wr falls asynchronously.

Test Plan:
- Load mem[0]=SUB R1,R1->R1 (0x154), mem[1]=HALT (0x800); pulse start -> wr high exactly one cycle with addr1=1/addr2=1/addr3=1/ALUControl=001; Datapath R1=0; done pulse 4 cycles after start accepted; busy low after.
- Program from the Datapath bring-up sequence (R1<-R1-R1, R0<-R2+R1, R2<-R1-R3, R3<-R0+R3, HALT) with R2=-1, R3=1 initially -> final R0=FFFF..., R1=0, R2=FFFF..., R3=0; exactly 4 wr pulses.
- SUB R1,R1->R1 then BZ 5, with mem[5]=HALT and mem[2] an ALU op -> pc goes 0,1,5; no write from mem[2]. Repeat with BNZ 5 -> pc goes 0,1,2.
- mem[0]=JMP 0 (0xE00) -> no done; err pulses after 255 fetches; busy falls; wr never asserted.
- start with a concurrent prog_we to mem[0]=HALT -> done pulse, new instruction used. prog_we during a run -> memory unchanged (verified by a second run).
- Drive rst low during an EXEC cycle with wr=1 -> wr, busy and pc drop to 0 immediately; no done/err; a subsequent start runs normally.
